// File: rtl/cgra_config_loader.sv
// cgra_config_loader: streams host configuration beats onto the PE config bus and launches execution
module cgra_config_loader #(
    parameter int PE_NUM = 16,
    parameter int CONTEXT_SIZE = 8,
    parameter int INPUT_NUM = 8,
    parameter int OPERATION_BIT_LENGTH = 4,
    parameter int DATA_WIDTH = 32,
    localparam int CONTEXT_SIZE_BIT_LENGTH = $clog2(CONTEXT_SIZE),
    localparam int INPUT_NUM_BIT_LENGTH = $clog2(INPUT_NUM),
    localparam int PE_ID_W = $clog2(PE_NUM)
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               load_req,
    input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] load_context_max_id,
    input  logic                               stop_req,
    input  logic                               cfg_valid,
    output logic                               cfg_ready,
    input  logic [PE_ID_W-1:0]                 cfg_pe_id,
    input  logic [CONTEXT_SIZE_BIT_LENGTH-1:0] cfg_context,
    input  logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_in1,
    input  logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_in2,
    input  logic [OPERATION_BIT_LENGTH-1:0]    cfg_op,
    input  logic [DATA_WIDTH-1:0]              cfg_const,
    input  logic                               cfg_last,
    output logic [PE_NUM-1:0]                  write_config_data,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index,
    output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_1,
    output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_2,
    output logic [OPERATION_BIT_LENGTH-1:0]    config_op,
    output logic [DATA_WIDTH-1:0]              config_const_data,
    output logic                               start_exec,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id,
    output logic                               busy,
    output logic                               running,
    output logic                               cfg_error,
    output logic [15:0]                        write_count
);
    typedef enum logic [1:0] {IDLE, LOAD, START, RUN} state_t;
    state_t state;
    logic hs;
    logic beat_ok;
    // Handshake only while loading; a concurrent stop blocks acceptance so the abort is clean
    always_comb begin
        cfg_ready = (state == LOAD) && !stop_req;
        hs = cfg_valid && cfg_ready;
        beat_ok = (int'(cfg_pe_id) < PE_NUM) && (cfg_context <= mapping_context_max_id);
        busy = state != IDLE;
        running = state == RUN;
    end
    // Session FSM with the registered strobe, broadcast bus, launch pulse and bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            write_config_data <= '0;
            config_index <= '0;
            config_input_PE_index_1 <= '0;
            config_input_PE_index_2 <= '0;
            config_op <= '0;
            config_const_data <= '0;
            start_exec <= 1'b0;
            mapping_context_max_id <= '0;
            cfg_error <= 1'b0;
            write_count <= '0;
        end else begin
            write_config_data <= (hs && beat_ok) ? (PE_NUM'(1) << cfg_pe_id) : '0;
            start_exec <= 1'b0;
            if (hs && beat_ok) begin
                config_index <= cfg_context;
                config_input_PE_index_1 <= cfg_in1;
                config_input_PE_index_2 <= cfg_in2;
                config_op <= cfg_op;
                config_const_data <= cfg_const;
                write_count <= (write_count == 16'hFFFF) ? write_count : write_count + 16'd1;
            end
            if (hs && !beat_ok)
                cfg_error <= 1'b1;
            case (state)
                IDLE: if (load_req) begin
                    state <= LOAD;
                    mapping_context_max_id <= load_context_max_id;
                    cfg_error <= 1'b0;
                    write_count <= '0;
                end
                LOAD: if (stop_req)
                    state <= IDLE;
                else if (hs && cfg_last)
                    state <= START;
                START: begin
                    state <= RUN;
                    start_exec <= 1'b1;
                end
                RUN: if (stop_req)
                    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cgra_config_loader.sv
// tb_cgra_config_loader: randomized and directed checking of the config loader against a session-level model
module tb_cgra_config_loader;
    logic clk = 0, reset_n = 0, load_req = 0, stop_req = 0, cfg_valid = 0, cfg_last = 0;
    logic [2:0] load_context_max_id = 0, cfg_context = 0, cfg_in1 = 0, cfg_in2 = 0;
    logic [3:0] cfg_pe_id = 0, cfg_op = 0;
    logic [31:0] cfg_const = 0;
    logic cfg_ready, start_exec, busy, running, cfg_error;
    logic [15:0] write_config_data, write_count;
    logic [2:0] config_index, config_input_PE_index_1, config_input_PE_index_2, mapping_context_max_id;
    logic [3:0] config_op;
    logic [31:0] config_const_data;

    cgra_config_loader dut (
        .clk(clk), .reset_n(reset_n), .load_req(load_req), .load_context_max_id(load_context_max_id),
        .stop_req(stop_req), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_pe_id(cfg_pe_id),
        .cfg_context(cfg_context), .cfg_in1(cfg_in1), .cfg_in2(cfg_in2), .cfg_op(cfg_op),
        .cfg_const(cfg_const), .cfg_last(cfg_last), .write_config_data(write_config_data),
        .config_index(config_index), .config_input_PE_index_1(config_input_PE_index_1),
        .config_input_PE_index_2(config_input_PE_index_2), .config_op(config_op),
        .config_const_data(config_const_data), .start_exec(start_exec),
        .mapping_context_max_id(mapping_context_max_id), .busy(busy), .running(running),
        .cfg_error(cfg_error), .write_count(write_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0, n_start = 0, start_cyc = -1;
    logic [15:0] s_log[$];
    int s_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Session-level model: whether we are loading, launching or running, plus the beats written
    bit m_load = 0, m_launch = 0, m_run = 0;
    int m_beats = 0;
    logic [15:0] e_strobe = 0;
    logic [2:0] e_idx = 0, e_in1 = 0, e_in2 = 0, e_max = 0;
    logic [3:0] e_op = 0;
    logic [31:0] e_const = 0;
    bit e_start = 0, e_err = 0;

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_load = 0; m_launch = 0; m_run = 0; m_beats = 0;
            e_strobe = 0; e_idx = 0; e_in1 = 0; e_in2 = 0; e_max = 0; e_op = 0; e_const = 0;
            e_start = 0; e_err = 0;
        end else begin : step
            bit hs, ok;
            hs = m_load && !stop_req && cfg_valid;
            ok = hs && int'(cfg_pe_id) < 16 && cfg_context <= e_max;
            e_strobe = ok ? 16'(1 << cfg_pe_id) : 16'h0;
            if (ok) begin
                e_idx = cfg_context; e_in1 = cfg_in1; e_in2 = cfg_in2; e_op = cfg_op; e_const = cfg_const;
                m_beats++;
            end
            if (hs && !ok) e_err = 1;
            e_start = m_launch;
            if (!m_load && !m_launch && !m_run) begin
                if (load_req) begin m_load = 1; e_max = load_context_max_id; e_err = 0; m_beats = 0; end
            end else if (m_load) begin
                if (stop_req) m_load = 0;
                else if (hs && cfg_last) begin m_load = 0; m_launch = 1; end
            end else if (m_launch) begin
                m_launch = 0; m_run = 1;
            end else if (stop_req) m_run = 0;
        end
    end

    // Compare every cycle, well clear of the clock edges, and log strobes/launches for literal checks
    always @(negedge clk) begin
        #3;
        chk("strobe", write_config_data, e_strobe);
        chk("index", config_index, e_idx);
        chk("in1", config_input_PE_index_1, e_in1);
        chk("in2", config_input_PE_index_2, e_in2);
        chk("op", config_op, e_op);
        chk("const", config_const_data, e_const);
        chk("start_exec", start_exec, e_start);
        chk("max_id", mapping_context_max_id, e_max);
        chk("busy", busy, m_load || m_launch || m_run);
        chk("running", running, m_run);
        chk("cfg_error", cfg_error, e_err);
        chk("write_count", write_count, m_beats > 65535 ? 65535 : m_beats);
        chk("cfg_ready", cfg_ready, m_load && !stop_req);
        if (write_config_data != 0) begin s_log.push_back(write_config_data); s_cyc.push_back(cyc); end
        if (start_exec) begin n_start++; start_cyc = cyc; end
    end

    task automatic idle();
        @(negedge clk);
        load_req = 0; stop_req = 0; cfg_valid = 0; cfg_last = 0;
    endtask

    task automatic load(input logic [2:0] max_id);
        @(negedge clk);
        load_req = 1; stop_req = 0; cfg_valid = 0; cfg_last = 0; load_context_max_id = max_id;
        @(negedge clk);
        load_req = 0;
    endtask

    task automatic stop();
        @(negedge clk);
        load_req = 0; stop_req = 1; cfg_valid = 0; cfg_last = 0;
        @(negedge clk);
        stop_req = 0;
    endtask

    task automatic beat(input logic [3:0] pe, input logic [2:0] ctx, input logic [3:0] op,
                        input logic [31:0] c, input logic last);
        @(negedge clk);
        load_req = 0; stop_req = 0; cfg_valid = 1; cfg_pe_id = pe; cfg_context = ctx;
        cfg_in1 = ctx; cfg_in2 = 3'(pe); cfg_op = op; cfg_const = c; cfg_last = last;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : main
        int st;
        wait_cycles(2);
        #1 reset_n = 1;
        #1;
        chk("rst_strobe", write_config_data, 16'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", write_count, 16'h0);
        chk("rst_max", mapping_context_max_id, 3'h0);

        // Three-beat session with max context 2
        load(3'd2);
        s_log.delete(); s_cyc.delete(); st = n_start;
        beat(4'd3, 3'd0, 4'd1, 32'h0, 1'b0);
        beat(4'd3, 3'd1, 4'd5, 32'h2A, 1'b0);
        beat(4'd0, 3'd2, 4'd7, 32'h0, 1'b1);
        idle();
        wait_cycles(3);
        #1;
        chk("a_nstrobe", s_log.size(), 3);
        if (s_log.size() == 3) begin
            chk("a_s0", s_log[0], 16'h0008);
            chk("a_s1", s_log[1], 16'h0008);
            chk("a_s2", s_log[2], 16'h0001);
            chk("a_gapless", s_cyc[2] - s_cyc[0], 2);
            chk("a_start_after", start_cyc, s_cyc[2] + 1);
        end
        chk("a_nstart", n_start - st, 1);
        chk("a_running", running, 1'b1);
        chk("a_count", write_count, 16'd3);
        chk("a_op", config_op, 4'd7);

        // load_req while running is ignored; stop_req ends the run
        load(3'd5);
        #1;
        chk("run_max_kept", mapping_context_max_id, 3'd2);
        chk("run_still", running, 1'b1);
        stop();
        #1;
        chk("run_stopped", busy, 1'b0);

        // Out-of-range context is dropped and flagged
        load(3'd2);
        beat(4'd5, 3'd3, 4'd2, 32'h11, 1'b0);
        idle();
        #1;
        chk("err_set", cfg_error, 1'b1);
        chk("err_nocount", write_count, 16'd0);
        // Stop together with a valid last beat: nothing accepted, no launch
        st = n_start;
        beat(4'd1, 3'd0, 4'd3, 32'h5, 1'b1);
        stop_req = 1;
        #1;
        chk("stop_ready", cfg_ready, 1'b0);
        idle();
        #1;
        chk("stop_idle", busy, 1'b0);
        chk("stop_count", write_count, 16'd0);
        wait_cycles(2);
        chk("stop_nostart", n_start - st, 0);
        load(3'd7);
        #1;
        chk("err_cleared", cfg_error, 1'b0);

        // Back-to-back beats with cfg_valid held high
        s_log.delete(); s_cyc.delete();
        beat(4'd2, 3'd7, 4'd1, 32'h1, 1'b0);
        beat(4'd9, 3'd4, 4'd2, 32'h2, 1'b0);
        beat(4'd15, 3'd0, 4'd3, 32'h3, 1'b0);
        beat(4'd6, 3'd1, 4'd4, 32'h4, 1'b1);
        idle();
        wait_cycles(3);
        chk("b2b_n", s_log.size(), 4);
        if (s_log.size() == 4) begin
            chk("b2b_span", s_cyc[3] - s_cyc[0], 3);
            chk("b2b_last", s_log[3], 16'h0040);
            chk("b2b_start", start_cyc, s_cyc[3] + 1);
        end
        stop();

        // Async reset mid-load with a strobe in flight
        load(3'd7);
        beat(4'd4, 3'd0, 4'd1, 32'h9, 1'b0);
        beat(4'd8, 3'd1, 4'd1, 32'hA, 1'b0);
        @(negedge clk);
        #1 reset_n = 0;
        #1;
        chk("mid_rst_strobe", write_config_data, 16'h0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_count", write_count, 16'h0);
        chk("mid_rst_ready", cfg_ready, 1'b0);
        cfg_valid = 0;
        @(negedge clk);
        #1 reset_n = 1;

        // Randomized traffic, with occasional async resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            load_req = ($urandom % 4) == 0;
            stop_req = ($urandom % 24) == 0;
            load_context_max_id = 3'($urandom);
            cfg_valid = ($urandom % 3) != 0;
            cfg_pe_id = 4'($urandom);
            cfg_context = 3'($urandom);
            cfg_in1 = 3'($urandom);
            cfg_in2 = 3'($urandom);
            cfg_op = 4'($urandom);
            cfg_const = $urandom;
            cfg_last = ($urandom % 8) == 0;
            if (($urandom % 400) == 0) begin
                #1 reset_n = 0;
                @(negedge clk);
                #1 reset_n = 1;
            end
        end
        idle();
        wait_cycles(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
